// File: rtl/uart_tx_drain_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, frame geometry
// and the clocks-per-bit computation reused by the receive side.
package uart_tx_drain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int unsigned DATA_BITS = 8;

    function automatic int unsigned calc_cpb(input int unsigned clk_freq, input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Free-running 0..CPB-1 bit-period counter with synchronous clear; tick marks
// the last clock of each bit period.
module uart_baud_cnt #(
    parameter int unsigned CPB = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    import uart_tx_drain_pkg::*;

    localparam int unsigned CW = (CPB > 1) ? $clog2(CPB) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CW'(CPB - 1));

    // next count: clear wins, otherwise wrap at the bit boundary
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = {CW{1'b0}};
        end else if (tick) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // counter register
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_drain.sv
// Drains a show-ahead byte FIFO onto an 8N1 UART line, chaining frames with
// no idle gap while bytes remain. All outputs come straight from flops.
module uart_tx_drain #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] fifo_dout,
    input  logic       fifo_empty,
    output logic       fifo_deq,
    output logic       tx,
    output logic       busy
);
    import uart_tx_drain_pkg::*;

    localparam int unsigned CPB = calc_cpb(CLK_FREQ, BAUD);
    localparam int unsigned BW  = $clog2(DATA_BITS);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 deq_q, deq_d;
    logic                 clear_s;
    logic                 tick_s;

    uart_baud_cnt #(.CPB(CPB)) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (clear_s),
        .tick  (tick_s)
    );

    // next-state, shift register and pop strobe
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        deq_d     = 1'b0;
        clear_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                clear_s = 1'b1;
                if (!fifo_empty) begin
                    shreg_d = fifo_dout;
                    deq_d   = 1'b1;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    state_d   = ST_DATA;
                    bit_idx_d = {BW{1'b0}};
                    clear_s   = 1'b1;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    if (bit_idx_q == BW'(DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                        clear_s = 1'b1;
                    end else begin
                        shreg_d   = {1'b0, shreg_q[DATA_BITS-1:1]};
                        bit_idx_d = bit_idx_q + {{(BW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                // the last stop clock doubles as the sampling point for the next byte
                if (tick_s) begin
                    clear_s = 1'b1;
                    if (!fifo_empty) begin
                        shreg_d = fifo_dout;
                        deq_d   = 1'b1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // line level follows the state being entered so tx is registered yet aligned
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_IDLE:  tx_d = 1'b1;
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shreg_d[0];
            ST_STOP:  tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            shreg_q   <= {DATA_BITS{1'b0}};
            bit_idx_q <= {BW{1'b0}};
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            deq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            deq_q     <= deq_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign fifo_deq = deq_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: behavioural show-ahead FIFO, scoreboard of expected
// bytes, and a UART receiver monitor that decodes and compares each frame.
module tb_uart_tx_drain;

    localparam int unsigned CLK_FREQ = 1000;
    localparam int unsigned BAUD     = 100;
    localparam int          CPB      = 10;
    localparam int          FRAME    = 10 * CPB;

    logic       clk        = 1'b0;
    logic       reset      = 1'b0;
    logic [7:0] fifo_dout  = 8'h00;
    logic       fifo_empty = 1'b1;
    logic       fifo_deq;
    logic       tx;
    logic       busy;
    logic       wr_en      = 1'b0;
    logic [7:0] wr_data    = 8'h00;

    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    int         start_log[$];
    int         n_vec = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         deq_cnt = 0;
    int         busy_falls = 0;
    int         last_fall_cyc = 0;
    bit         rx_busy = 1'b0;
    logic       tx_prev = 1'b1;
    logic       busy_prev = 1'b0;
    int         rx_cnt = 0;
    logic [9:0] rx_sh = 10'h000;

    uart_tx_drain #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_deq   (fifo_deq),
        .tx         (tx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // show-ahead FIFO with registered flags, independent of the DUT reset
    initial forever begin
        @(posedge clk);
        cyc++;
        if (fifo_deq === 1'b1 && fq.size() > 0) void'(fq.pop_front());
        if (wr_en) fq.push_back(wr_data);
        fifo_empty <= (fq.size() == 0);
        fifo_dout  <= (fq.size() > 0) ? fq[0] : 8'h00;
    end

    // monitor: deq/busy bookkeeping and UART receiver feeding the scoreboard
    initial forever begin
        @(negedge clk);
        if (fifo_deq === 1'b1) begin
            deq_cnt++;
            check("deq_while_empty", {31'd0, fifo_empty}, 32'd0);
        end
        if (busy_prev === 1'b1 && busy === 1'b0) begin
            busy_falls++;
            last_fall_cyc = cyc;
        end
        busy_prev = busy;
        if (reset !== 1'b1) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (tx_prev === 1'b1 && tx === 1'b0) begin
                rx_busy = 1'b1;
                rx_cnt  = 0;
                start_log.push_back(cyc);
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % CPB == CPB / 2) begin
                rx_sh[rx_cnt / CPB] = tx;
                if (rx_cnt / CPB == 9) begin
                    rx_busy = 1'b0;
                    check("start_bit", {31'd0, rx_sh[0]}, 32'd0);
                    check("stop_bit", {31'd0, rx_sh[9]}, 32'd1);
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got %0h expected none", rx_sh[8:1]);
                    end else begin
                        check("rx_byte", {24'd0, rx_sh[8:1]}, {24'd0, exp_q.pop_front()});
                    end
                end
            end
        end
        tx_prev = (reset !== 1'b1) ? 1'b1 : tx;
    end

    task automatic enq(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        exp_q.push_back(b);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (!(busy === 1'b0 && fifo_empty && !rx_busy && exp_q.size() == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, {31'd0, n < budget}, 32'd1);
    endtask

    initial begin
        int         d0, s0, f0, errs, berrs, nfr;
        logic [9:0] pat;

        // 1: reset held with a non-empty FIFO
        reset = 1'b0;
        @(negedge clk);
        enq(8'h5A);
        for (int i = 0; i < 3; i++) begin
            check("t1_tx", {31'd0, tx}, 32'd1);
            check("t1_busy", {31'd0, busy}, 32'd0);
            check("t1_deq", {31'd0, fifo_deq}, 32'd0);
            check("t1_fifo_count", fq.size(), 32'd1);
            @(negedge clk);
        end
        reset = 1'b1;
        wait_idle("t1", 300);

        // 2: single byte 0xA5, cycle-exact waveform
        repeat (5) @(negedge clk);
        d0  = deq_cnt;
        pat = {1'b1, 8'hA5, 1'b0};
        wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
        @(negedge clk);
        wr_en = 1'b0;
        check("t2_deq_before", {31'd0, fifo_deq}, 32'd0);
        check("t2_tx_before", {31'd0, tx}, 32'd1);
        @(negedge clk);
        check("t2_deq_pulse", {31'd0, fifo_deq}, 32'd1);
        errs = 0; berrs = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (tx !== pat[i / CPB]) errs++;
            if (busy !== 1'b1) berrs++;
            @(negedge clk);
        end
        check("t2_tx_pattern_errs", errs, 32'd0);
        check("t2_busy_errs", berrs, 32'd0);
        check("t2_busy_end", {31'd0, busy}, 32'd0);
        check("t2_empty_end", {31'd0, fifo_empty}, 32'd1);
        check("t2_deq_count", deq_cnt - d0, 32'd1);
        wait_idle("t2", 50);

        // 3: back-to-back bytes
        s0 = start_log.size(); d0 = deq_cnt; f0 = busy_falls;
        enq(8'h00); enq(8'hFF); enq(8'h55);
        wait_idle("t3", 500);
        nfr = start_log.size() - s0;
        check("t3_frames", nfr, 32'd3);
        if (nfr == 3) begin
            check("t3_gap1", start_log[s0+1] - start_log[s0], FRAME);
            check("t3_gap2", start_log[s0+2] - start_log[s0+1], FRAME);
        end
        check("t3_deq_count", deq_cnt - d0, 32'd3);
        check("t3_busy_falls", busy_falls - f0, 32'd1);

        // 4: second byte arrives while the first is in DATA
        repeat (5) @(negedge clk);
        s0 = start_log.size(); d0 = deq_cnt; f0 = busy_falls;
        enq(8'h11);
        repeat (30) @(negedge clk);
        enq(8'h3C);
        wait_idle("t4", 400);
        nfr = start_log.size() - s0;
        check("t4_frames", nfr, 32'd2);
        if (nfr == 2) check("t4_gap", start_log[s0+1] - start_log[s0], FRAME);
        check("t4_deq_count", deq_cnt - d0, 32'd2);
        check("t4_busy_falls", busy_falls - f0, 32'd1);

        // 5: reset during data bit 4 of 0x81
        repeat (5) @(negedge clk);
        d0 = deq_cnt;
        enq(8'h81);
        repeat (56) @(negedge clk);
        check("t5_mid_bit4_tx", {31'd0, tx}, 32'd0);
        check("t5_mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        check("t5_abort_tx", {31'd0, tx}, 32'd1);
        check("t5_abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        errs = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0) errs++;
            @(negedge clk);
        end
        check("t5_quiet_errs", errs, 32'd0);
        check("t5_deq_count", deq_cnt - d0, 32'd1);

        // 6: drain 64 bytes
        s0 = start_log.size(); d0 = deq_cnt;
        for (int i = 0; i < 64; i++) enq(8'(i));
        wait_idle("t6", 8000);
        nfr = start_log.size() - s0;
        check("t6_frames", nfr, 32'd64);
        check("t6_deq_count", deq_cnt - d0, 32'd64);
        if (nfr == 64) begin
            check("t6_span", start_log[s0+63] - start_log[s0], 63 * FRAME);
            check("t6_total", last_fall_cyc - start_log[s0], 64 * FRAME);
        end
        check("t6_end_busy", {31'd0, busy}, 32'd0);
        check("t6_end_tx", {31'd0, tx}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
